// File: rtl/mips_mc_main_ctrl_pkg.sv
// Shared constants for the multicycle MIPS main control: state encodings,
// opcodes, mux selects and the packed control-word type. ADDI support: MC_CTRL_ADDI_EN.
package mc_ctrl_pkg;

   localparam int MC_STATE_BITS = 4;

   typedef enum logic [MC_STATE_BITS-1:0] {
      S_RESET     = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_MEM_ADDR  = 4'd3,
      S_MEM_READ  = 4'd4,
      S_MEM_WB    = 4'd5,
      S_MEM_WRITE = 4'd6,
      S_EXECUTE   = 4'd7,
      S_R_WB      = 4'd8,
      S_BRANCH    = 4'd9,
      S_JUMP      = 4'd10,
      S_ILLEGAL   = 4'd11,
      S_ADDI_EXEC = 4'd12,
      S_ADDI_WB   = 4'd13
   } mc_state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG_B  = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_source;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       instr_done;
      logic       illegal_op;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '0;

   // Opcode dispatch taken out of DECODE.
   function automatic logic [MC_STATE_BITS-1:0] dispatch_state(input logic [5:0] op);
      logic [MC_STATE_BITS-1:0] ns;
      ns = S_ILLEGAL;
      case (op)
         OP_RTYPE:     ns = S_EXECUTE;
         OP_LW, OP_SW: ns = S_MEM_ADDR;
         OP_BEQ:       ns = S_BRANCH;
         OP_J:         ns = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
         OP_ADDI:      ns = S_ADDI_EXEC;
`endif
         default:      ns = S_ILLEGAL;
      endcase
      return ns;
   endfunction

endpackage

// File: rtl/mips_mc_main_ctrl_decode.sv
// Purely combinational state -> control-word decoder (Moore outputs).
// ADDI states decode only when MC_CTRL_ADDI_EN is defined.
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic [STATE_W-1:0] i_state,
   output ctrl_t              o_ctrl
);

   always_comb begin
      o_ctrl = CTRL_IDLE;
      case (i_state)
         STATE_W'(S_FETCH): begin
            o_ctrl.mem_read  = 1'b1;
            o_ctrl.ir_write  = 1'b1;
            o_ctrl.pc_write  = 1'b1;
            o_ctrl.alu_src_b = SRCB_FOUR;
            o_ctrl.pc_source = PCSRC_ALU;
         end
         STATE_W'(S_DECODE): begin
            o_ctrl.alu_src_b = SRCB_IMM_SH;
         end
         STATE_W'(S_MEM_ADDR): begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_IMM;
         end
         STATE_W'(S_MEM_READ): begin
            o_ctrl.mem_read = 1'b1;
            o_ctrl.iord     = 1'b1;
         end
         STATE_W'(S_MEM_WB): begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.mem_to_reg = 1'b1;
            o_ctrl.instr_done = 1'b1;
         end
         STATE_W'(S_MEM_WRITE): begin
            o_ctrl.mem_write  = 1'b1;
            o_ctrl.iord       = 1'b1;
            o_ctrl.instr_done = 1'b1;
         end
         STATE_W'(S_EXECUTE): begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_REG_B;
            o_ctrl.alu_op    = ALUOP_FUNCT;
         end
         STATE_W'(S_R_WB): begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.reg_dst    = 1'b1;
            o_ctrl.instr_done = 1'b1;
         end
         STATE_W'(S_BRANCH): begin
            o_ctrl.alu_src_a     = 1'b1;
            o_ctrl.alu_op        = ALUOP_SUB;
            o_ctrl.pc_write_cond = 1'b1;
            o_ctrl.pc_source     = PCSRC_ALUOUT;
            o_ctrl.instr_done    = 1'b1;
         end
         STATE_W'(S_JUMP): begin
            o_ctrl.pc_write   = 1'b1;
            o_ctrl.pc_source  = PCSRC_JUMP;
            o_ctrl.instr_done = 1'b1;
         end
         STATE_W'(S_ILLEGAL): begin
            o_ctrl.illegal_op = 1'b1;
         end
`ifdef MC_CTRL_ADDI_EN
         STATE_W'(S_ADDI_EXEC): begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_IMM;
            o_ctrl.alu_op    = ALUOP_ADD;
         end
         STATE_W'(S_ADDI_WB): begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.instr_done = 1'b1;
         end
`endif
         // S_RESET and unused encodings drive nothing.
         default: o_ctrl = CTRL_IDLE;
      endcase
   end

endmodule

// File: rtl/mips_mc_main_ctrl.sv
// Multicycle MIPS main control FSM: state register, reset hold counter,
// next-state logic and pc_en. Optional ADDI path: MC_CTRL_ADDI_EN.
module mips_mc_main_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int STATE_W           = 4,
   parameter int RESET_VECTOR_HOLD = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         opcode,
   input  logic               zero,
   output logic               PCWrite,
   output logic               PCWriteCond,
   output logic               pc_en,
   output logic [1:0]         PCSource,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               MemtoReg,
   output logic               RegDst,
   output logic               RegWrite,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ALU_Op,
   output logic               instr_done,
   output logic               illegal_op,
   output logic [STATE_W-1:0] state
);

   localparam logic [3:0] HOLD_LAST = 4'(RESET_VECTOR_HOLD - 1);

   logic [STATE_W-1:0] r_state;
   logic [STATE_W-1:0] w_state_next;
   logic [3:0]         r_hold_cnt;
   logic [3:0]         w_hold_cnt_next;
   ctrl_t              w_ctrl;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= STATE_W'(S_RESET);
         r_hold_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_hold_cnt <= w_hold_cnt_next;
      end
   end

   always_comb begin
      w_state_next    = STATE_W'(S_FETCH);
      w_hold_cnt_next = '0;
      case (r_state)
         STATE_W'(S_RESET): begin
            if (r_hold_cnt == HOLD_LAST) begin
               w_state_next = STATE_W'(S_FETCH);
            end else begin
               w_state_next    = STATE_W'(S_RESET);
               w_hold_cnt_next = r_hold_cnt + 4'd1;
            end
         end
         STATE_W'(S_FETCH):    w_state_next = STATE_W'(S_DECODE);
         STATE_W'(S_DECODE):   w_state_next = STATE_W'(dispatch_state(opcode));
         STATE_W'(S_MEM_ADDR): w_state_next = (opcode == OP_LW) ? STATE_W'(S_MEM_READ)
                                                                 : STATE_W'(S_MEM_WRITE);
         STATE_W'(S_MEM_READ): w_state_next = STATE_W'(S_MEM_WB);
         STATE_W'(S_EXECUTE):  w_state_next = STATE_W'(S_R_WB);
`ifdef MC_CTRL_ADDI_EN
         STATE_W'(S_ADDI_EXEC): w_state_next = STATE_W'(S_ADDI_WB);
`endif
         // Final states, ILLEGAL and unused encodings all return to FETCH.
         default:              w_state_next = STATE_W'(S_FETCH);
      endcase
   end

   mc_ctrl_decode #(
      .STATE_W (STATE_W)
   ) u_decode (
      .i_state (r_state),
      .o_ctrl  (w_ctrl)
   );

   assign PCWrite     = w_ctrl.pc_write;
   assign PCWriteCond = w_ctrl.pc_write_cond;
   assign pc_en       = w_ctrl.pc_write | (w_ctrl.pc_write_cond & zero);
   assign PCSource    = w_ctrl.pc_source;
   assign IorD        = w_ctrl.iord;
   assign MemRead     = w_ctrl.mem_read;
   assign MemWrite    = w_ctrl.mem_write;
   assign IRWrite     = w_ctrl.ir_write;
   assign MemtoReg    = w_ctrl.mem_to_reg;
   assign RegDst      = w_ctrl.reg_dst;
   assign RegWrite    = w_ctrl.reg_write;
   assign ALUSrcA     = w_ctrl.alu_src_a;
   assign ALUSrcB     = w_ctrl.alu_src_b;
   assign ALU_Op      = w_ctrl.alu_op;
   assign instr_done  = w_ctrl.instr_done;
   assign illegal_op  = w_ctrl.illegal_op;
   assign state       = r_state;

endmodule

// File: tb/tb_mips_mc_main_ctrl.sv
// Table-driven cycle-by-cycle check of the multicycle main control,
// plus a hand sequence for asynchronous reset in the middle of lw.
module tb_mips_mc_main_ctrl;
   import mc_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode;
   logic       zero;
   logic       PCWrite, PCWriteCond, pc_en, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done, illegal_op;
   logic [1:0] PCSource, ALUSrcB, ALU_Op;
   logic [3:0] state;

   mips_mc_main_ctrl #(.STATE_W(4), .RESET_VECTOR_HOLD(1)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .pc_en(pc_en),
      .PCSource(PCSource), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALU_Op(ALU_Op),
      .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
   );

   always #5 clk = ~clk;

   // Observed outputs packed in a fixed order for one-shot comparison.
   logic [18:0] got;
   assign got = {PCWrite, PCWriteCond, pc_en, PCSource, IorD, MemRead, MemWrite,
                 IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALU_Op,
                 instr_done, illegal_op};

   localparam logic [18:0] M_PCW     = 19'd1 << 18;
   localparam logic [18:0] M_PCWC    = 19'd1 << 17;
   localparam logic [18:0] M_PCEN    = 19'd1 << 16;
   localparam logic [18:0] M_PCS_01  = 19'd1 << 14;
   localparam logic [18:0] M_PCS_10  = 19'd2 << 14;
   localparam logic [18:0] M_IORD    = 19'd1 << 13;
   localparam logic [18:0] M_MRD     = 19'd1 << 12;
   localparam logic [18:0] M_MWR     = 19'd1 << 11;
   localparam logic [18:0] M_IRW     = 19'd1 << 10;
   localparam logic [18:0] M_M2R     = 19'd1 << 9;
   localparam logic [18:0] M_RDST    = 19'd1 << 8;
   localparam logic [18:0] M_RWR     = 19'd1 << 7;
   localparam logic [18:0] M_SRCA    = 19'd1 << 6;
   localparam logic [18:0] M_SRCB_01 = 19'd1 << 4;
   localparam logic [18:0] M_SRCB_10 = 19'd2 << 4;
   localparam logic [18:0] M_SRCB_11 = 19'd3 << 4;
   localparam logic [18:0] M_AOP_01  = 19'd1 << 2;
   localparam logic [18:0] M_AOP_10  = 19'd2 << 2;
   localparam logic [18:0] M_DONE    = 19'd1 << 1;
   localparam logic [18:0] M_ILL     = 19'd1 << 0;

   localparam logic [18:0] E_NONE     = 19'd0;
   localparam logic [18:0] E_FETCH    = M_PCW | M_PCEN | M_MRD | M_IRW | M_SRCB_01;
   localparam logic [18:0] E_DECODE   = M_SRCB_11;
   localparam logic [18:0] E_MADDR    = M_SRCA | M_SRCB_10;
   localparam logic [18:0] E_MREAD    = M_MRD | M_IORD;
   localparam logic [18:0] E_MWB      = M_RWR | M_M2R | M_DONE;
   localparam logic [18:0] E_MWRITE   = M_MWR | M_IORD | M_DONE;
   localparam logic [18:0] E_EXEC     = M_SRCA | M_AOP_10;
   localparam logic [18:0] E_RWB      = M_RWR | M_RDST | M_DONE;
   localparam logic [18:0] E_BR_TAKEN = M_SRCA | M_AOP_01 | M_PCWC | M_PCS_01 | M_DONE | M_PCEN;
   localparam logic [18:0] E_BR_NOT   = M_SRCA | M_AOP_01 | M_PCWC | M_PCS_01 | M_DONE;
   localparam logic [18:0] E_JUMP     = M_PCW | M_PCEN | M_PCS_10 | M_DONE;
   localparam logic [18:0] E_ILLEGAL  = M_ILL;
   localparam logic [18:0] E_AEXEC    = M_SRCA | M_SRCB_10;
   localparam logic [18:0] E_AWB      = M_RWR | M_DONE;

   localparam logic [5:0] JUNK = 6'b111111;

   typedef struct {
      logic [5:0]  op;
      logic        z;
      logic [3:0]  st;
      logic [18:0] exp;
   } vec_t;

   vec_t tbl[$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic add(input logic [5:0] op, input logic z, input logic [3:0] st,
                      input logic [18:0] exp);
      vec_t v;
      v.op = op; v.z = z; v.st = st; v.exp = exp;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) begin
         n_pass++;
         $display("ok   %s got=%0h", nm, act);
      end else begin
         $display("FAIL %s got=%0h want=%0h", nm, act, req);
      end
   endtask

   initial begin
      opcode = JUNK;
      zero   = 1'b1;

      // One row per clock starting from the first cycle after reset release.
      add(JUNK,     1'b1, S_RESET,     E_NONE);
      add(JUNK,     1'b1, S_FETCH,     E_FETCH);
      add(OP_LW,    1'b0, S_DECODE,    E_DECODE);
      add(OP_LW,    1'b0, S_MEM_ADDR,  E_MADDR);
      add(OP_SW,    1'b1, S_MEM_READ,  E_MREAD);
      add(JUNK,     1'b1, S_MEM_WB,    E_MWB);
      add(OP_RTYPE, 1'b0, S_FETCH,     E_FETCH);
      add(OP_RTYPE, 1'b0, S_DECODE,    E_DECODE);
      add(OP_BEQ,   1'b0, S_EXECUTE,   E_EXEC);
      add(JUNK,     1'b1, S_R_WB,      E_RWB);
      add(JUNK,     1'b0, S_FETCH,     E_FETCH);
      add(OP_SW,    1'b0, S_DECODE,    E_DECODE);
      add(OP_SW,    1'b0, S_MEM_ADDR,  E_MADDR);
      add(OP_LW,    1'b1, S_MEM_WRITE, E_MWRITE);
      add(JUNK,     1'b0, S_FETCH,     E_FETCH);
      add(OP_BEQ,   1'b1, S_DECODE,    E_DECODE);
      add(JUNK,     1'b1, S_BRANCH,    E_BR_TAKEN);
      add(JUNK,     1'b0, S_FETCH,     E_FETCH);
      add(OP_BEQ,   1'b0, S_DECODE,    E_DECODE);
      add(OP_BEQ,   1'b0, S_BRANCH,    E_BR_NOT);
      add(JUNK,     1'b0, S_FETCH,     E_FETCH);
      add(OP_J,     1'b0, S_DECODE,    E_DECODE);
      add(JUNK,     1'b0, S_JUMP,      E_JUMP);
      add(JUNK,     1'b1, S_FETCH,     E_FETCH);
      add(JUNK,     1'b1, S_DECODE,    E_DECODE);
      add(OP_LW,    1'b1, S_ILLEGAL,   E_ILLEGAL);
      add(JUNK,     1'b0, S_FETCH,     E_FETCH);
      add(OP_ADDI,  1'b0, S_DECODE,    E_DECODE);
`ifdef MC_CTRL_ADDI_EN
      add(JUNK,     1'b1, S_ADDI_EXEC, E_AEXEC);
      add(JUNK,     1'b1, S_ADDI_WB,   E_AWB);
`else
      add(JUNK,     1'b1, S_ILLEGAL,   E_ILLEGAL);
`endif
      add(JUNK,     1'b0, S_FETCH,     E_FETCH);

      // Held in reset: everything idle even with zero=1.
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      chk("reset_state", 32'(state), 32'(S_RESET));
      chk("reset_outputs", 32'(got), 32'(E_NONE));

      @(negedge clk);
      rst_n = 1'b1;
      foreach (tbl[i]) begin
         opcode = tbl[i].op;
         zero   = tbl[i].z;
         #1;
         chk($sformatf("row%0d_state", i), 32'(state), 32'(tbl[i].st));
         chk($sformatf("row%0d_outputs", i), 32'(got), 32'(tbl[i].exp));
         @(negedge clk);
      end

      // Asynchronous reset while lw sits in MEM_READ.
      rst_n = 1'b0; #1;
      rst_n = 1'b1;
      opcode = OP_LW;
      zero   = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      chk("midrst_pre_state", 32'(state), 32'(S_MEM_READ));
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_state_now", 32'(state), 32'(S_RESET));
      chk("midrst_outputs_now", 32'(got), 32'(E_NONE));
      @(negedge clk); #1;
      chk("midrst_state_held", 32'(state), 32'(S_RESET));
      chk("midrst_outputs_held", 32'(got), 32'(E_NONE));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("release_state0", 32'(state), 32'(S_RESET));
      @(negedge clk); #1;
      chk("release_state1", 32'(state), 32'(S_FETCH));
      chk("release_outputs1", 32'(got), 32'(E_FETCH));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
